// File: rtl/sprite_hit_bank.sv
// sprite_hit_bank: per-pixel hit test against N double-buffered sprite boxes,
// 2-cycle pipeline with lowest-index priority and a per-frame collision flag.
`default_nettype none

module sprite_hit_bank #(
    parameter int N_SPRITES = 4,
    parameter int COORD_W   = 10,
    parameter int HALF_W    = 26,
    parameter int HALF_H    = 30,
    localparam int IDX_W    = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
    input  logic                 Clk_i,
    input  logic                 Reset_i,
    input  logic                 frame_sync_i,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [COORD_W-1:0]   wr_centerx_i,
    input  logic [COORD_W-1:0]   wr_centery_i,
    input  logic                 wr_visible_i,
    input  logic [COORD_W-1:0]   DrawX_i,
    input  logic [COORD_W-1:0]   DrawY_i,
    input  logic                 pix_valid_i,
    output logic                 hit_valid_o,
    output logic [N_SPRITES-1:0] hit_mask_o,
    output logic                 hit_any_o,
    output logic [IDX_W-1:0]     hit_idx_o,
    output logic                 collide_o
);

    localparam logic signed [COORD_W:0] C_HW = (COORD_W+1)'(HALF_W);
    localparam logic signed [COORD_W:0] C_HH = (COORD_W+1)'(HALF_H);

    logic [COORD_W-1:0]   sh_cx_q  [N_SPRITES];
    logic [COORD_W-1:0]   sh_cy_q  [N_SPRITES];
    logic [N_SPRITES-1:0] sh_vis_q;
    logic [COORD_W-1:0]   act_cx_q [N_SPRITES];
    logic [COORD_W-1:0]   act_cy_q [N_SPRITES];
    logic [N_SPRITES-1:0] act_vis_q;

    logic                 wr_ok_d;
    logic [N_SPRITES-1:0] cov_d;
    logic                 s1_valid_q;
    logic [N_SPRITES-1:0] s1_mask_q;
    logic [IDX_W-1:0]     hit_idx_d;
    logic                 multi_d;
    logic                 hit_valid_q;
    logic [N_SPRITES-1:0] hit_mask_q;
    logic                 hit_any_q;
    logic [IDX_W-1:0]     hit_idx_q;
    logic                 collide_pending_q;
    logic                 collide_q;

    assign wr_ok_d = wr_en_i && (int'(wr_idx_i) < N_SPRITES);

    // A write in the frame_sync cycle bypasses the shadow straight into active.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                sh_cx_q[i]  <= '0;
                sh_cy_q[i]  <= '0;
                act_cx_q[i] <= '0;
                act_cy_q[i] <= '0;
            end
            sh_vis_q  <= '0;
            act_vis_q <= '0;
        end else begin
            for (int i = 0; i < N_SPRITES; i++) begin
                if (wr_ok_d && (int'(wr_idx_i) == i)) begin
                    sh_cx_q[i]  <= wr_centerx_i;
                    sh_cy_q[i]  <= wr_centery_i;
                    sh_vis_q[i] <= wr_visible_i;
                end
                if (frame_sync_i) begin
                    if (wr_ok_d && (int'(wr_idx_i) == i)) begin
                        act_cx_q[i]  <= wr_centerx_i;
                        act_cy_q[i]  <= wr_centery_i;
                        act_vis_q[i] <= wr_visible_i;
                    end else begin
                        act_cx_q[i]  <= sh_cx_q[i];
                        act_cy_q[i]  <= sh_cy_q[i];
                        act_vis_q[i] <= sh_vis_q[i];
                    end
                end
            end
        end
    end

    // Zero-extended signed differences so coordinates never wrap around the screen edge.
    for (genvar g = 0; g < N_SPRITES; g++) begin : g_cov
        logic signed [COORD_W:0] dx_d;
        logic signed [COORD_W:0] dy_d;
        assign dx_d = $signed({1'b0, DrawX_i}) - $signed({1'b0, act_cx_q[g]});
        assign dy_d = $signed({1'b0, DrawY_i}) - $signed({1'b0, act_cy_q[g]});
        assign cov_d[g] = act_vis_q[g] && (dx_d >= -C_HW) && (dx_d <= C_HW)
                                       && (dy_d >= -C_HH) && (dy_d <= C_HH);
    end

    always_comb begin
        hit_idx_d = '0;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (s1_mask_q[i]) hit_idx_d = IDX_W'(i);
        end
    end

    assign multi_d = s1_valid_q && (|(s1_mask_q & (s1_mask_q - N_SPRITES'(1))));

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            s1_valid_q        <= 1'b0;
            s1_mask_q         <= '0;
            hit_valid_q       <= 1'b0;
            hit_mask_q        <= '0;
            hit_any_q         <= 1'b0;
            hit_idx_q         <= '0;
            collide_pending_q <= 1'b0;
            collide_q         <= 1'b0;
        end else begin
            s1_valid_q  <= pix_valid_i;
            s1_mask_q   <= pix_valid_i ? cov_d : '0;
            hit_valid_q <= s1_valid_q;
            hit_mask_q  <= s1_mask_q;
            hit_any_q   <= |s1_mask_q;
            hit_idx_q   <= hit_idx_d;
            if (frame_sync_i) begin
                collide_q         <= collide_pending_q | multi_d;
                collide_pending_q <= 1'b0;
            end else begin
                collide_pending_q <= collide_pending_q | multi_d;
            end
        end
    end

    assign hit_valid_o = hit_valid_q;
    assign hit_mask_o  = hit_mask_q;
    assign hit_any_o   = hit_any_q;
    assign hit_idx_o   = hit_idx_q;
    assign collide_o   = collide_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_hit_bank.sv
// Randomized and directed bench for sprite_hit_bank against an array-based reference model.
`default_nettype none

module tb_sprite_hit_bank;

    localparam int N = 4;
    localparam int HW = 26;
    localparam int HH = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b0, fs = 1'b0, we = 1'b0, wvis = 1'b0, pv = 1'b0;
    logic [1:0] widx = '0;
    logic [9:0] wcx = '0, wcy = '0, dx = '0, dy = '0;
    logic       hit_valid, hit_any, collide;
    logic [3:0] hit_mask;
    logic [1:0] hit_idx;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int  sh_cx[N], sh_cy[N], a_cx[N], a_cy[N];
    bit  sh_v[N], a_v[N];
    bit  p1_v, p2_v, pend, coll;
    bit [3:0] p1_m, p2_m;

    always #5 clk = ~clk;

    sprite_hit_bank #(.N_SPRITES(N), .COORD_W(10), .HALF_W(HW), .HALF_H(HH)) dut (
        .Clk_i(clk), .Reset_i(rst), .frame_sync_i(fs), .wr_en_i(we), .wr_idx_i(widx),
        .wr_centerx_i(wcx), .wr_centery_i(wcy), .wr_visible_i(wvis),
        .DrawX_i(dx), .DrawY_i(dy), .pix_valid_i(pv),
        .hit_valid_o(hit_valid), .hit_mask_o(hit_mask), .hit_any_o(hit_any),
        .hit_idx_o(hit_idx), .collide_o(collide)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [3:0] covers(input int x, input int y);
        bit [3:0] m = '0;
        for (int i = 0; i < N; i++) begin
            int ddx = x - a_cx[i];
            int ddy = y - a_cy[i];
            if (ddx < 0) ddx = -ddx;
            if (ddy < 0) ddy = -ddy;
            m[i] = a_v[i] && (ddx <= HW) && (ddy <= HH);
        end
        return m;
    endfunction

    function automatic int lowest(input bit [3:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                sh_cx[i] = 0; sh_cy[i] = 0; sh_v[i] = 0;
                a_cx[i] = 0; a_cy[i] = 0; a_v[i] = 0;
            end
            p1_v = 0; p2_v = 0; p1_m = '0; p2_m = '0; pend = 0; coll = 0;
        end else begin
            bit multi = p1_v && ($countones(p1_m) >= 2);
            p2_v = p1_v; p2_m = p1_m;
            p1_v = pv;
            p1_m = pv ? covers(int'(dx), int'(dy)) : 4'b0;
            if (fs) begin coll = pend | multi; pend = 0; end
            else pend = pend | multi;
            if (we && int'(widx) < N) begin
                sh_cx[widx] = int'(wcx); sh_cy[widx] = int'(wcy); sh_v[widx] = wvis;
            end
            if (fs) for (int i = 0; i < N; i++) begin
                a_cx[i] = sh_cx[i]; a_cy[i] = sh_cy[i]; a_v[i] = sh_v[i];
            end
        end
    endtask

    task automatic step(input bit r, input bit f, input bit w, input int idx,
                        input int cx, input int cy, input bit v,
                        input bit p, input int x, input int y);
        @(negedge clk);
        rst = r; fs = f; we = w; widx = 2'(idx); wcx = 10'(cx); wcy = 10'(cy); wvis = v;
        pv = p; dx = 10'(x); dy = 10'(y);
        @(posedge clk);
        model_edge();
        #1;
        chk("hit_valid", 32'(hit_valid), 32'(p2_v));
        chk("hit_mask", 32'(hit_mask), p2_v ? 32'(p2_m) : 32'd0);
        chk("hit_any", 32'(hit_any), 32'(p2_v && (p2_m != 0)));
        chk("hit_idx", 32'(hit_idx), p2_v ? 32'(lowest(p2_m)) : 32'd0);
        chk("collide", 32'(collide), 32'(coll));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pix(input int x, input int y);
        step(0, 0, 0, 0, 0, 0, 0, 1, x, y);
    endtask

    task automatic wr(input int idx, input int cx, input int cy, input bit v);
        step(0, 0, 1, idx, cx, cy, v, 0, 0, 0);
    endtask

    task automatic fsync();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 50, 50, 1, 1, 50, 50);
        chk("rst_valid", 32'(hit_valid), 0);
        chk("rst_collide", 32'(collide), 0);

        // inclusive horizontal edges
        wr(0, 100, 100, 1);
        fsync();
        pix(74, 100); pix(73, 100);
        chk("edge_x74", 32'(hit_mask), 32'h1);
        pix(126, 100);
        chk("edge_x73", 32'(hit_mask), 32'h0);
        pix(127, 100);
        chk("edge_x126", 32'(hit_mask), 32'h1);
        idle();
        chk("edge_x127", 32'(hit_mask), 32'h0);

        // overlap and per-frame collision flag
        wr(0, 0, 0, 0); wr(1, 100, 100, 1); wr(2, 110, 100, 1);
        fsync();
        pix(105, 100); idle();
        chk("ovl_mask", 32'(hit_mask), 32'h6);
        chk("ovl_idx", 32'(hit_idx), 32'd1);
        fsync();
        chk("collide_set", 32'(collide), 32'd1);
        pix(300, 300); idle(); idle();
        chk("collide_hold", 32'(collide), 32'd1);
        fsync();
        chk("collide_clear", 32'(collide), 32'd0);

        // no wrap-around at the screen edges
        wr(1, 0, 0, 0); wr(2, 0, 0, 0); wr(0, 5, 100, 1);
        fsync();
        pix(0, 100); pix(1020, 100);
        chk("wrap_x0", 32'(hit_mask), 32'h1);
        idle();
        chk("wrap_x1020", 32'(hit_mask), 32'h0);
        wr(0, 1020, 100, 1); fsync();
        pix(1023, 100); pix(3, 100);
        chk("wrap_x1023", 32'(hit_mask), 32'h1);
        idle();
        chk("wrap_x3", 32'(hit_mask), 32'h0);

        // shadow vs active, and same-cycle write bypass
        wr(3, 500, 500, 1);
        pix(500, 500); idle();
        chk("shadow_only", 32'(hit_mask), 32'h0);
        fsync(); pix(500, 500); idle();
        chk("after_sync", 32'(hit_mask), 32'h8);
        step(0, 1, 1, 3, 600, 600, 1, 0, 0, 0);
        pix(600, 600); idle();
        chk("bypass", 32'(hit_mask), 32'h8);

        // invisible slot never hits
        wr(2, 200, 200, 0); fsync();
        pix(200, 200); idle();
        chk("invis_mask", 32'(hit_mask), 32'h0);
        chk("invis_any", 32'(hit_any), 32'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bit r = ($urandom_range(0, 299) == 0);
            bit f = ($urandom_range(0, 39) == 0);
            bit w = ($urandom_range(0, 7) == 0);
            step(r, f, w, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
                 $urandom_range(0, 255), $urandom_range(0, 255));
        end

        // mid-stream reset
        wr(0, 100, 100, 1); fsync();
        pix(100, 100); pix(100, 100);
        step(1, 1, 1, 1, 100, 100, 1, 1, 100, 100);
        chk("mid_rst_valid", 32'(hit_valid), 0);
        chk("mid_rst_mask", 32'(hit_mask), 0);
        pix(100, 100);
        chk("post_rst1", 32'(hit_valid), 0);
        pix(100, 100);
        chk("post_rst2", 32'(hit_valid), 1);
        chk("post_rst_mask", 32'(hit_mask), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
